// File: rtl/rv_ex_operand_stage.sv
// ID/EX operand stage: registers decoded operands, decodes the ALU opcode and forwards EX/MEM and
// MEM/WB results onto the ALU inputs. Defining RV_EX_STAGE_PERF_EN adds the perf_stall_cnt output.
module rv_ex_operand_stage #(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_rs1_data,
   input  logic [DW-1:0] in_rs2_data,
   input  logic [DW-1:0] in_imm,
   input  logic [RW-1:0] in_rs1_addr,
   input  logic [RW-1:0] in_rs2_addr,
   input  logic [RW-1:0] in_rd_addr,
   input  logic          in_alu_src,
   input  logic [1:0]    in_alu_ctl,
   input  logic [2:0]    in_funct3,
   input  logic          in_funct7_5,
   input  logic          in_reg_write,
   input  logic          flush,
   input  logic          fwd_em_we,
   input  logic [RW-1:0] fwd_em_rd,
   input  logic [DW-1:0] fwd_em_data,
   input  logic          fwd_mw_we,
   input  logic [RW-1:0] fwd_mw_rd,
   input  logic [DW-1:0] fwd_mw_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_in1,
   output logic [DW-1:0] out_in2,
   output logic [3:0]    out_aluop,
   output logic [DW-1:0] out_store_data,
   output logic [RW-1:0] out_rd,
   output logic          out_reg_write,
   output logic          out_illegal
`ifdef RV_EX_STAGE_PERF_EN
   ,
   output logic [31:0]   perf_stall_cnt
`endif
);

   logic          r_valid;
   logic [DW-1:0] r_rs1_data;
   logic [DW-1:0] r_rs2_data;
   logic [DW-1:0] r_imm;
   logic [RW-1:0] r_rs1_addr;
   logic [RW-1:0] r_rs2_addr;
   logic [RW-1:0] r_rd;
   logic          r_alu_src;
   logic [3:0]    r_aluop;
   logic          r_illegal;
   logic          r_reg_write;

   logic          w_capture;
   logic          w_em_hit1;
   logic          w_mw_hit1;
   logic          w_em_hit2;
   logic          w_mw_hit2;
   logic [DW-1:0] w_fwd1;
   logic [DW-1:0] w_fwd2;
   logic [4:0]    w_dec;

   // Returns {illegal, aluop}; unsupported encodings fall back to ADD with illegal set.
   function automatic logic [4:0] f_decode(input logic [1:0] ctl, input logic [2:0] f3,
                                           input logic f7, input logic src);
      logic [4:0] v;
      v = {1'b0, 4'b0010};
      case (ctl)
         2'b00: v = {1'b0, 4'b0010};
         2'b01: v = {1'b0, 4'b0110};
         2'b10: begin
            case (f3)
               3'b000:  v = {1'b0, (f7 && !src) ? 4'b0110 : 4'b0010};
               3'b111:  v = {1'b0, 4'b0000};
               3'b110:  v = {1'b0, 4'b0001};
               3'b010:  v = {1'b0, 4'b0111};
               default: v = {1'b1, 4'b0010};
            endcase
         end
         default: v = {1'b1, 4'b0010};
      endcase
      return v;
   endfunction

   assign in_ready  = !r_valid || out_ready;
   assign w_capture = in_valid && in_ready;
   assign w_dec     = f_decode(in_alu_ctl, in_funct3, in_funct7_5, in_alu_src);

   // Requiring rd != 0 also guarantees that rs address 0 never picks up a forward.
   assign w_em_hit1 = fwd_em_we && (fwd_em_rd == r_rs1_addr) && (fwd_em_rd != '0);
   assign w_mw_hit1 = fwd_mw_we && (fwd_mw_rd == r_rs1_addr) && (fwd_mw_rd != '0);
   assign w_em_hit2 = fwd_em_we && (fwd_em_rd == r_rs2_addr) && (fwd_em_rd != '0);
   assign w_mw_hit2 = fwd_mw_we && (fwd_mw_rd == r_rs2_addr) && (fwd_mw_rd != '0);

   assign w_fwd1 = w_em_hit1 ? fwd_em_data : (w_mw_hit1 ? fwd_mw_data : r_rs1_data);
   assign w_fwd2 = w_em_hit2 ? fwd_em_data : (w_mw_hit2 ? fwd_mw_data : r_rs2_data);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid     <= 1'b0;
         r_rs1_data  <= '0;
         r_rs2_data  <= '0;
         r_imm       <= '0;
         r_rs1_addr  <= '0;
         r_rs2_addr  <= '0;
         r_rd        <= '0;
         r_alu_src   <= 1'b0;
         r_aluop     <= '0;
         r_illegal   <= 1'b0;
         r_reg_write <= 1'b0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (w_capture) begin
         r_valid     <= 1'b1;
         r_rs1_data  <= in_rs1_data;
         r_rs2_data  <= in_rs2_data;
         r_imm       <= in_imm;
         r_rs1_addr  <= in_rs1_addr;
         r_rs2_addr  <= in_rs2_addr;
         r_rd        <= in_rd_addr;
         r_alu_src   <= in_alu_src;
         r_aluop     <= w_dec[3:0];
         r_illegal   <= w_dec[4];
         r_reg_write <= in_reg_write;
      end else if (r_valid && out_ready) begin
         r_valid <= 1'b0;
      end else if (r_valid) begin
         // Stalled: latch any forwarded value so it survives the producer retiring.
         r_rs1_data <= w_fwd1;
         r_rs2_data <= w_fwd2;
      end
   end

`ifdef RV_EX_STAGE_PERF_EN
   logic [31:0] r_stall_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
      end else if (r_valid && !out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign perf_stall_cnt = r_stall_cnt;
`endif

   assign out_valid      = r_valid;
   assign out_in1        = w_fwd1;
   assign out_in2        = r_alu_src ? r_imm : w_fwd2;
   assign out_store_data = w_fwd2;
   assign out_aluop      = r_aluop;
   assign out_rd         = r_rd;
   assign out_reg_write  = r_reg_write && r_valid;
   assign out_illegal    = r_illegal;

endmodule

// File: doc/rv_ex_operand_stage.md
Name: rv_ex_operand_stage

Overview:
- ID/EX pipeline stage that sits directly upstream of the ALU.
- Registers decoded operands and generates the 4-bit ALU opcode from the decode control fields.
- Applies EX/MEM and MEM/WB operand forwarding and drives the ALU inputs `in1`, `in2` and `ALUop`.
- Uses a valid/ready handshake with hold (stall) and flush (bubble) support.

Parameters:
- DW, 32, datapath width; must match the ALU's DW.
- RW, 5, register-address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  decode has a valid instruction.
- in_ready  out  1  stage can accept; equals !out_valid || out_ready.
- in_rs1_data, in_rs2_data  in  DW  register-file read data.
- in_imm  in  DW  sign-extended immediate.
- in_rs1_addr, in_rs2_addr, in_rd_addr  in  RW  register addresses.
- in_alu_src  in  1  1 = in2 uses the immediate.
- in_alu_ctl  in  2  00 = add (ld/st), 01 = sub (branch), 10 = funct decode, 11 = reserved.
- in_funct3  in  3  instruction funct3.
- in_funct7_5  in  1  instruction bit 30.
- in_reg_write  in  1  instruction writes rd.
- flush  in  1  kill the held instruction and the incoming one.
- fwd_em_we, fwd_em_rd, fwd_em_data  in  1/RW/DW  EX/MEM forwarding source.
- fwd_mw_we, fwd_mw_rd, fwd_mw_data  in  1/RW/DW  MEM/WB forwarding source.
- out_valid  out  1  outputs hold a valid instruction.
- out_ready  in  1  downstream consumes this cycle.
- out_in1, out_in2  out  DW  ALU operands.
- out_aluop  out  4  ALU opcode.
- out_store_data  out  DW  forwarded rs2, for stores.
- out_rd  out  RW  destination register.
- out_reg_write  out  1  registered in_reg_write, gated by out_valid.
- out_illegal  out  1  unsupported ALU encoding.

Behaviour:
- Reset values: out_valid = 0; all stored fields = 0; out_reg_write = 0; out_illegal = 0.
- Transfer: a word is captured when in_valid && in_ready. out_valid is set next cycle (1-cycle latency).
- Drain: if out_valid && out_ready and there is no new capture, out_valid clears next cycle.
- Hold: if out_valid && !out_ready, all stored fields hold, except operand refresh (below).
- Flush has priority over everything. Next cycle out_valid = 0; the incoming word is not captured; stored data is don't-care.
- Flush is also honoured while out_valid && !out_ready.
- Forwarding is combinational, applied to the stored rs1/rs2 data using the current fwd_* inputs.
  - A source hits when we = 1, rd == stored rs address, and rd != 0.
  - EX/MEM beats MEM/WB when both hit.
  - rs address 0 never forwards.
- Operand refresh: while holding, a forward hit on rs1 or rs2 writes the forwarded value into the stored register. This keeps the value valid after the producer retires.
- out_in1 = fwd(rs1).
- out_in2 = in_alu_src ? imm : fwd(rs2); the select is registered.
- out_store_data = fwd(rs2).
- ALUop generation is registered at capture.
  - in_alu_ctl 00 → 0010; 01 → 0110.
  - in_alu_ctl 10, funct3 000: 0110 if funct7_5 && !alu_src, else 0010.
  - in_alu_ctl 10, funct3 111 → 0000; 110 → 0001; 010 → 0111.
  - Any other funct3, or in_alu_ctl 11: aluop = 0010 and out_illegal = 1.
- out_reg_write = stored reg_write && out_valid.
- Reset mid-hold: reset wins immediately (asynchronous); out_valid = 0.

Optional Feature:
- Macro: RV_EX_STAGE_PERF_EN.
- Enabled: adds output perf_stall_cnt, 32 bits. It increments each cycle out_valid && !out_ready, saturates at 0xFFFFFFFF, and resets to 0.
- Disabled: the port and counter do not exist. Behaviour is otherwise identical.

Test Plan:
- R-type ADD, rs1 = 5, rs2 = 7, funct7_5 = 0, alu_ctl = 10, funct3 = 000 → next cycle: out_valid = 1, out_in1 = 5, out_in2 = 7, aluop = 0010.
- ADDI with funct7_5 = 1, alu_src = 1, imm = 0xFFFFFFFF → aluop = 0010 (not SUB), out_in2 = 0xFFFFFFFF.
- Forwarding with both sources hitting rs1 = 3:
  - fwd_em(3, 0xAA) and fwd_mw(3, 0xBB) → out_in1 = 0xAA.
  - Same hits with rs1 = 0 → out_in1 = stored rs1_data.
- Hold with out_ready = 0 for 3 cycles; cycle 1 fwd_mw(rs2, 0x55), then the forward is removed → out_in2 stays 0x55. in_ready = 0 throughout; perf_stall_cnt = 3 (if enabled).
- Flush while holding, with in_valid = 1 → out_valid = 0 next cycle; the new word is not captured.
- Illegal encodings: funct3 = 100 with alu_ctl = 10, then alu_ctl = 11 → out_illegal = 1, aluop = 0010 in both cases.
